hamming_secded_enc: RTL and testbench
=====================================

// Module: hamming_secded_enc
//
// PURPOSE
//   Parametrised Hamming SEC-DED encoder with valid/ready flow control.
//   Accepts DATA_W-bit data words and emits each word with its Hamming check bits and,
//   optionally, an overall parity bit for double-error detection.
//   Output is 1 or 2 pipeline stages later, with full backpressure support.
//   Sits between the pattern source and the storage/channel model of the ECC generator.
//
// PARAMETERS
//   DATA_W  32  data word width, 4..247
//   SECDED  1   1: append overall parity bit (SEC-DED); 0: plain Hamming SEC
//   PIPE    1   1: extra register stage after parity computation (latency 2); 0: latency 1
//   R_W     derived (localparam): smallest r with 2**r >= DATA_W+r+1 (6 for DATA_W=32)
//   PAR_W   derived (localparam): R_W+SECDED
//
// PORTS
//   i_clk      in   1       clock, all logic on rising edge
//   i_rst_n    in   1       synchronous reset, active low
//   i_en       in   1       global enable; 0 freezes every register and forces o_ready=0
//   i_valid    in   1       input word valid
//   o_ready    out  1       encoder can accept a word this cycle
//   i_pattern  in   DATA_W  data word
//   o_valid    out  1       output word valid
//   i_ready    in   1       downstream accepts output this cycle
//   o_pattern  out  DATA_W  data word, unmodified
//   o_parity   out  PAR_W   [R_W-1:0] Hamming check bits; [PAR_W-1] overall parity when SECDED=1
//   o_count    out  32      number of words accepted at the output (o_valid & i_ready & i_en), wraps
//
// BEHAVIOUR
//   Reset (i_rst_n=0 at the clock edge):
//     - all stage-valid flags, o_valid and o_count go to 0
//     - o_pattern/o_parity registers go to 0
//     - o_ready = 0 during reset, 1 in the first cycle after reset
//     - an in-flight word is discarded
//   Code construction:
//     - codeword positions 1..DATA_W+R_W; positions 2**k hold check bit k
//     - data bit i goes to the i-th non-power-of-two position, LSB first
//     - check bit k = XOR of all data bits whose position has bit k set
//     - overall parity = XOR of all data bits and all R_W check bits (even parity)
//   Pipeline:
//     - S1 registers i_pattern and the computed parity on a transfer (i_valid & o_ready & i_en)
//     - PIPE=1: S2 registers S1 contents; outputs drive from S2. PIPE=0: outputs drive from S1
//     - a stage loads when it is empty or its contents advance in the same cycle
//     - o_ready = i_en & (!S1_full | S1 advances); combinational from i_ready (no skid buffer)
//     - with i_ready held 1, throughput is one word per clock; latency from input transfer
//       to o_valid is 1+PIPE cycles
//     - o_valid holds with o_pattern/o_parity stable until i_ready=1 (AXI-style rule)
//     - o_valid never depends combinationally on i_ready
//   Ordering: words leave in input order; no word is dropped or duplicated.
//   Simultaneous events:
//     - input and output transfers in the same cycle with the pipeline full: both occur,
//       and occupancy is unchanged
//     - i_en=0 overrides everything except reset: no transfer, o_count holds, outputs hold
//   o_count: +1 per output transfer; 32'hFFFF_FFFF wraps to 0.
//   Words with i_valid=0 are ignored, and i_pattern is then don't-care.
//
// TESTING
//   1. DATA_W=8, SECDED=1, PIPE=1: i_pattern=8'h01 -> 2 cycles later o_pattern=8'h01,
//      o_parity=5'h13.
//   2. DATA_W=8: i_pattern=8'hFF -> o_parity=5'h03; 8'h00 -> o_parity=5'h00;
//      SECDED=0 with 8'h01 -> o_parity=4'h3.
//   3. Back-to-back: 16 words with i_ready=1 -> 16 consecutive o_valid cycles in order,
//      o_count=16.
//   4. Backpressure: i_ready=0 for 5 cycles with a continuous input stream -> o_ready drops
//      after PIPE+1 words are held; outputs stable; on release, no loss or duplication.
//   5. i_en=0 for 3 cycles mid-stream -> all state and outputs frozen, o_ready=0;
//      stream resumes intact.
//   6. Reset with 2 words in flight -> o_valid=0 and o_count=0 next cycle;
//      the next input produces correct parity.
//   Also: a random-data scoreboard against a reference encoder for DATA_W in {8,32,64};
//   decoding with any single-bit flip corrects it; with SECDED=1, any double flip is
//   flagged as uncorrectable.

Source files
------------

// File: rtl/hamming_secded_enc.sv
// rtl/hamming_secded_enc.sv - Hamming SEC-DED encoder with valid/ready pipeline
// Check bits are computed combinationally at the input and carried through 1 or 2 register stages.
module hamming_secded_enc #(
  parameter int DATA_W = 32,
  parameter int SECDED = 1,
  parameter int PIPE   = 1,
  localparam int R_W   = (DATA_W <= 4)   ? 3 :
                         (DATA_W <= 11)  ? 4 :
                         (DATA_W <= 26)  ? 5 :
                         (DATA_W <= 57)  ? 6 :
                         (DATA_W <= 120) ? 7 : 8,
  localparam int PAR_W = R_W + SECDED
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_pattern,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_pattern,
  output logic [PAR_W-1:0]  o_parity,
  output logic [31:0]       o_count
);

  // Codeword position of data bit i: skip every power-of-two slot at or below it.
  function automatic int data_pos(input int i);
    int p;
    p = i + 1;
    for (int k = 0; k < R_W; k++)
      if ((1 << k) <= p) p = p + 1;
    return p;
  endfunction

  logic [R_W-1:0]    chk;
  logic [PAR_W-1:0]  enc_par;
  logic              s1_full_q, s1_full_d;
  logic [DATA_W-1:0] s1_pat_q, s1_pat_d;
  logic [PAR_W-1:0]  s1_par_q, s1_par_d;
  logic [31:0]       count_q, count_d;
  logic              out_valid, out_fire, s1_adv, in_fire;
  logic [DATA_W-1:0] out_pat;
  logic [PAR_W-1:0]  out_par;

  always_comb begin
    chk = '0;
    for (int i = 0; i < DATA_W; i++)
      for (int k = 0; k < R_W; k++)
        if (((data_pos(i) >> k) & 1) != 0)
          chk[k] = chk[k] ^ i_pattern[i];
  end

  if (SECDED != 0) begin : g_secded
    assign enc_par = {(^i_pattern) ^ (^chk), chk};
  end else begin : g_sec
    assign enc_par = chk;
  end

  assign out_fire = i_en & out_valid & i_ready;
  assign o_ready  = i_rst_n & i_en & (!s1_full_q | s1_adv);
  assign in_fire  = i_valid & o_ready;
  assign count_d  = count_q + {31'b0, out_fire};

  always_comb begin
    s1_full_d = s1_full_q;
    s1_pat_d  = s1_pat_q;
    s1_par_d  = s1_par_q;
    if (in_fire) begin
      s1_full_d = 1'b1;
      s1_pat_d  = i_pattern;
      s1_par_d  = enc_par;
    end else if (s1_adv) begin
      s1_full_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_full_q <= 1'b0;
      s1_pat_q  <= '0;
      s1_par_q  <= '0;
      count_q   <= '0;
    end else begin
      s1_full_q <= s1_full_d;
      s1_pat_q  <= s1_pat_d;
      s1_par_q  <= s1_par_d;
      count_q   <= count_d;
    end
  end

  if (PIPE != 0) begin : g_pipe
    logic              s2_full_q, s2_full_d;
    logic [DATA_W-1:0] s2_pat_q, s2_pat_d;
    logic [PAR_W-1:0]  s2_par_q, s2_par_d;

    assign s1_adv = i_en & s1_full_q & (!s2_full_q | out_fire);

    always_comb begin
      s2_full_d = s2_full_q;
      s2_pat_d  = s2_pat_q;
      s2_par_d  = s2_par_q;
      if (s1_adv) begin
        s2_full_d = 1'b1;
        s2_pat_d  = s1_pat_q;
        s2_par_d  = s1_par_q;
      end else if (out_fire) begin
        s2_full_d = 1'b0;
      end
    end

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        s2_full_q <= 1'b0;
        s2_pat_q  <= '0;
        s2_par_q  <= '0;
      end else begin
        s2_full_q <= s2_full_d;
        s2_pat_q  <= s2_pat_d;
        s2_par_q  <= s2_par_d;
      end
    end

    assign out_valid = s2_full_q;
    assign out_pat   = s2_pat_q;
    assign out_par   = s2_par_q;
  end else begin : g_nopipe
    assign s1_adv    = out_fire;
    assign out_valid = s1_full_q;
    assign out_pat   = s1_pat_q;
    assign out_par   = s1_par_q;
  end

  assign o_valid   = out_valid;
  assign o_pattern = out_pat;
  assign o_parity  = out_par;
  assign o_count   = count_q;

endmodule

// File: tb/tb_hamming_secded_enc.sv
// tb/tb_hamming_secded_enc.sv - directed bench for hamming_secded_enc (DATA_W=8)
// Main instance is SECDED=1/PIPE=1; a SECDED=0/PIPE=0 instance shares the inputs.
module tb_hamming_secded_enc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, in_valid, out_ready;
  logic [7:0]  in_pat;
  logic        d_ready, d_valid, s_ready, s_valid;
  logic [7:0]  d_pat, s_pat;
  logic [4:0]  d_par;
  logic [3:0]  s_par;
  logic [31:0] d_count, s_count;

  hamming_secded_enc #(.DATA_W(8), .SECDED(1), .PIPE(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_valid(in_valid), .o_ready(d_ready),
    .i_pattern(in_pat), .o_valid(d_valid), .i_ready(out_ready), .o_pattern(d_pat),
    .o_parity(d_par), .o_count(d_count));

  hamming_secded_enc #(.DATA_W(8), .SECDED(0), .PIPE(0)) u_sec (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_valid(in_valid), .o_ready(s_ready),
    .i_pattern(in_pat), .o_valid(s_valid), .i_ready(out_ready), .o_pattern(s_pat),
    .o_parity(s_par), .o_count(s_count));

  int checks = 0, failures = 0, cyc = 0, n_out = 0;
  logic [7:0] cur;
  logic [7:0] exp_q[$];
  logic [7:0] got_pat_q[$];
  logic [4:0] got_par_q[$];
  int         got_cyc_q[$];
  logic [7:0] first_w;
  logic       sv_valid;
  logic [7:0] sv_pat;
  logic [4:0] sv_par;
  logic [31:0] sv_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n && en && out_ready && d_valid) begin
      got_pat_q.push_back(d_pat);
      got_par_q.push_back(d_par);
      got_cyc_q.push_back(cyc);
    end

  // Reference: walk codeword positions 1..12, data fills non-power-of-two slots.
  function automatic logic [4:0] ref_par(input logic [7:0] d);
    logic [3:0] c;
    int di;
    c = '0;
    di = 0;
    for (int p = 1; p <= 12; p++)
      if ((p & (p - 1)) != 0) begin
        for (int k = 0; k < 4; k++)
          if (((p >> k) & 1) == 1) c[k] = c[k] ^ d[di];
        di++;
      end
    return {(^d) ^ (^c), c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_pat_q.delete();
    got_par_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic send_one(input logic [7:0] pat, input logic [4:0] exp, input logic [3:0] exp_sec);
    tick(); in_valid = 1'b1; in_pat = pat; out_ready = 1'b0; en = 1'b1; #1;
    chk("one_ready", d_ready, 1);
    tick(); in_valid = 1'b0; #1;
    chk("one_lat1_valid", d_valid, 0);
    chk("sec_valid", s_valid, 1);
    chk("sec_pat", s_pat, pat);
    chk("sec_par", s_par, exp_sec);
    tick(); #1;
    chk("one_valid", d_valid, 1);
    chk("one_pat", d_pat, pat);
    chk("one_par", d_par, exp);
    out_ready = 1'b1;
    tick(); out_ready = 1'b0; #1;
    n_out++;
    chk("one_gone", d_valid, 0);
    chk("one_count", d_count, n_out);
  endtask

  task automatic src_cycle(input logic rdy, input logic e);
    tick(); in_valid = 1'b1; in_pat = cur; out_ready = rdy; en = e; #1;
    if (d_ready) begin
      exp_q.push_back(cur);
      cur = 8'($urandom);
    end
  endtask

  task automatic drain();
    for (int j = 0; j < 5; j++) begin
      tick(); in_valid = 1'b0; out_ready = 1'b1; en = 1'b1;
    end
    #1;
  endtask

  task automatic compare_q(input string tag);
    chk({tag, "_n"}, got_pat_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < got_pat_q.size(); j++) begin
      chk({tag, "_pat"}, got_pat_q[j], exp_q[j]);
      chk({tag, "_par"}, got_par_q[j], ref_par(exp_q[j]));
    end
    n_out += exp_q.size();
    chk({tag, "_count"}, d_count, n_out);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_pat = '0;
    cur = 8'($urandom);
    tick(); tick(); tick(); #1;
    chk("rst_ready", d_ready, 0);
    chk("rst_valid", d_valid, 0);
    chk("rst_count", d_count, 0);
    chk("rst_pat", d_pat, 0);
    chk("rst_par", d_par, 0);
    tick(); rst_n = 1'b1; #1;
    chk("post_rst_ready", d_ready, 1);

    send_one(8'h01, 5'h13, 4'h3);
    send_one(8'hFF, 5'h03, 4'h3);
    send_one(8'h00, 5'h00, 4'h0);
    send_one(8'h80, 5'h1C, 4'hC);

    // Back-to-back stream
    clear_q();
    for (int j = 0; j < 16; j++) begin
      src_cycle(1'b1, 1'b1);
      chk("b2b_ready", d_ready, 1);
    end
    drain();
    compare_q("b2b");
    if (got_cyc_q.size() == 16)
      chk("b2b_consecutive", got_cyc_q[15] - got_cyc_q[0], 15);

    // Backpressure: two words fill the pipe, then o_ready drops
    clear_q();
    for (int c = 0; c < 12; c++) begin
      src_cycle(c >= 5, 1'b1);
      if (c == 0) first_w = exp_q[0];
      chk("bp_ready", d_ready, (c < 2 || c >= 5) ? 1 : 0);
      if (c < 2) chk("bp_valid_early", d_valid, 0);
      if (c >= 2 && c <= 4) begin
        chk("bp_valid_hold", d_valid, 1);
        chk("bp_pat_hold", d_pat, first_w);
        chk("bp_par_hold", d_par, ref_par(first_w));
      end
    end
    drain();
    compare_q("bp");

    // Enable low for three cycles mid-stream
    clear_q();
    for (int c = 0; c < 10; c++) begin
      src_cycle(1'b1, !(c >= 4 && c <= 6));
      chk("en_ready", d_ready, (c >= 4 && c <= 6) ? 0 : 1);
      if (c == 4) begin
        sv_valid = d_valid; sv_pat = d_pat; sv_par = d_par; sv_cnt = d_count;
      end
      if (c >= 5 && c <= 7) begin
        chk("en_valid_frz", d_valid, sv_valid);
        chk("en_pat_frz", d_pat, sv_pat);
        chk("en_par_frz", d_par, sv_par);
        chk("en_count_frz", d_count, sv_cnt);
      end
    end
    drain();
    compare_q("en");

    // Reset with two words in flight
    clear_q();
    src_cycle(1'b0, 1'b1);
    src_cycle(1'b0, 1'b1);
    chk("inflight_n", exp_q.size(), 2);
    tick(); rst_n = 1'b0; in_valid = 1'b0; #1;
    chk("mid_rst_ready", d_ready, 0);
    tick(); rst_n = 1'b1; #1;
    chk("after_rst_valid", d_valid, 0);
    chk("after_rst_count", d_count, 0);
    chk("after_rst_ready", d_ready, 1);
    clear_q();
    n_out = 0;
    send_one(8'h0F, 5'h17, 4'h7);
    chk("after_rst_outputs", got_pat_q.size(), 1);
    if (got_pat_q.size() == 1) chk("after_rst_word", got_pat_q[0], 8'h0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
